svi_bus_arbiter: RTL and testbench
==================================

# svi_bus_arbiter

Round-robin arbiter and sequencer that shares one 8-bit x/y/z interface bundle between NREQ requesters. It sits between the requester-side interface array and the single shared bus instance. It grants exclusive bus ownership for a multi-beat burst, muxes the winner's x/y onto the bus, and returns the bus z data to the owner. An optional watchdog revokes a stalled grant.

## Interface
Parameters:
- NREQ, 4: number of requesters, 2..16.
- DW, 8: data width of x, y and z.
- TIMEOUT, 16: stall cycles before forced release. Used only with the watchdog.

Ports:
- clk  input  1  sole clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- req_i  input  NREQ  per-requester request; held for the whole burst.
- last_i  input  NREQ  marks the requester's final beat.
- x_i  input  NREQ*DW  packed per-requester x data; requester k occupies bits [k*DW +: DW].
- y_i  input  NREQ*DW  packed per-requester y data, same layout as x_i.
- gnt_o  output  NREQ  one-hot grant, registered.
- bus_valid_o  output  1  beat valid on the shared bus.
- bus_x_o, bus_y_o  output  DW  owner's x/y muxed onto the bus.
- bus_ready_i  input  1  shared bus accepts the beat.
- bus_z_i  input  DW  z returned by the shared bus.
- z_o  output  DW  registered z return.
- z_valid_o  output  NREQ  one-hot, marks which requester z_o belongs to.
- busy_o  output  1  state is OWN.
- timeout_o  output  1  one-cycle pulse on forced release.

## Operation
States:
- IDLE: all grants low.
  - If any req_i bit is set, pick the first set bit searching upward from ptr+1, wrapping modulo NREQ.
  - Register gnt_o to that one-hot value and record owner. Next state is OWN.
- OWN:
  - bus_valid_o = req_i[owner].
  - bus_x_o and bus_y_o carry the owner's slices. When nothing is granted, they are 0.
  - A beat is accepted when bus_valid_o and bus_ready_i are both high.
  - On an accepted beat, the next edge loads z_o from bus_z_i and pulses z_valid_o[owner] for one cycle.
- Release happens on any of the following. Each sets ptr to owner, clears gnt_o on the next edge and returns to IDLE:
  - an accepted beat with last_i[owner] high;
  - req_i[owner] dropping without last (burst abandoned, no z returned);
  - a watchdog expiry.
- After release there is always one IDLE cycle before the next grant, so the arbitration gap is fixed.
- Requests from non-owners while in OWN are ignored; they are arbitrated at the next IDLE.
- Fairness: a requester that was just released is searched last, so a continuously requesting set is served in strict rotation.

Reset values: state IDLE, ptr = NREQ-1 (requester 0 wins first), gnt_o 0, z_o 0, z_valid_o 0, timeout_o 0, watchdog counter 0. bus_valid_o, bus_x_o and bus_y_o are 0 while gnt_o is 0. Asserting rst_n low mid-burst drops the grant immediately; the in-flight beat is lost.

## Timing
- Arbitration latency: req_i seen high in IDLE at edge N gives gnt_o high after edge N. bus_valid_o can be high in that same cycle.
- bus_valid_o, bus_x_o and bus_y_o are combinational from the registered grant and the requester inputs. There is no path from bus_ready_i to bus_valid_o.
- z return latency is 1 cycle after acceptance.
- Burst of B beats with bus_ready_i held high: grant held for B cycles, then 1 IDLE cycle.
- Simultaneous events on the last beat: the release takes effect and the z_o update for that beat still occurs.

## Configuration
- SVI_ARB_WATCHDOG_EN defined:
  - A counter clears on grant and on every accepted beat, and increments in each OWN cycle without one.
  - When it reaches TIMEOUT, the block releases the owner and pulses timeout_o.
- SVI_ARB_WATCHDOG_EN undefined: no counter; timeout_o is tied to 0. A stalled owner holds the bus indefinitely.

## Structure
- Package svi_arb_pkg holds:
  - the state enum typedef (IDLE, OWN);
  - the default-width localparam.
- Sub-module svi_rr_pick is a combinational round-robin search.
  - Inputs: req vector and ptr.
  - Outputs: one-hot winner, its index and an any-request flag.
  - Reusable by other arbiters in the same hierarchy.

## Test plan
- Requester 2 only, 3-beat burst with bus_ready_i=1, x_i slice 0x55 -> gnt_o=4'b0100 one cycle after req, bus_x_o=0x55 for 3 cycles, three z_valid_o[2] pulses, then 1 IDLE cycle.
- All 4 requesting, single-beat bursts (last held high) -> grants in order 0,1,2,3,0, each separated by one IDLE cycle.
- Owner 1 with bus_ready_i=0 for 5 cycles, then 1 -> bus_valid_o held with stable x/y; one z return after acceptance; z_o equals bus_z_i sampled at the accepting edge.
- Owner drops req_i mid-burst, no last -> grant cleared next edge, no z_valid_o pulse, next requester granted after 1 IDLE cycle.
- Watchdog on, TIMEOUT=16, bus_ready_i=0 -> release after 16 OWN cycles, timeout_o one-cycle pulse, ptr advances past the stalled owner.
- rst_n asserted low mid-burst -> gnt_o, z_valid_o and bus_valid_o go to 0 immediately; after release, requester 0 wins first.

Source files
------------

// File: rtl/svi_arb_pkg.sv
// svi_arb_pkg: shared types and constants for the shared-bus arbiter family.
package svi_arb_pkg;

  // Default width of the x, y and z data.
  localparam int SVI_ARB_DW = 8;

  // Arbiter sequencer states.
  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } arb_state_e;

  // Width of an index that addresses n requesters; never narrower than 1 bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/svi_rr_pick.sv
// svi_rr_pick: combinational round-robin search.
// Scans req_i upward starting at ptr_i+1, wrapping modulo NREQ, and returns the
// first set bit as a one-hot vector plus its index. The requester at ptr_i is
// therefore considered last.
module svi_rr_pick
  import svi_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IW   = idx_width(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IW-1:0]   idx_o,
  output logic            any_o
);

  // First requester above the pointer, wrapping around.
  always_comb begin
    logic          found;
    logic [IW-1:0] k;
    gnt_o = '0;
    idx_o = '0;
    any_o = |req_i;
    found = 1'b0;
    k     = '0;
    for (int i = 1; i <= NREQ; i++) begin
      k = IW'((int'(ptr_i) + i) % NREQ);
      if (!found && req_i[k]) begin
        found    = 1'b1;
        gnt_o[k] = 1'b1;
        idx_o    = k;
      end
    end
  end

endmodule

// File: rtl/svi_bus_arbiter.sv
// svi_bus_arbiter: round-robin owner of one shared x/y/z bus among NREQ
// requesters. A winner keeps the bus for a whole burst; its x/y are muxed onto
// the bus and the returned z is handed back with a one-hot z_valid_o.
// Optional watchdog release of a stalled owner: define SVI_ARB_WATCHDOG_EN.
module svi_bus_arbiter
  import svi_arb_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int DW      = SVI_ARB_DW,
  parameter int TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req_i,
  input  logic [NREQ-1:0]    last_i,
  input  logic [NREQ*DW-1:0] x_i,
  input  logic [NREQ*DW-1:0] y_i,
  output logic [NREQ-1:0]    gnt_o,
  output logic               bus_valid_o,
  output logic [DW-1:0]      bus_x_o,
  output logic [DW-1:0]      bus_y_o,
  input  logic               bus_ready_i,
  input  logic [DW-1:0]      bus_z_i,
  output logic [DW-1:0]      z_o,
  output logic [NREQ-1:0]    z_valid_o,
  output logic               busy_o,
  output logic               timeout_o
);

  localparam int IW = idx_width(NREQ);

  arb_state_e      state_q;
  logic [NREQ-1:0] gnt_q;
  logic [IW-1:0]   owner_q;
  logic [IW-1:0]   ptr_q;
  logic [DW-1:0]   z_q;
  logic [NREQ-1:0] z_valid_q;
  logic            timeout_q;

  logic [NREQ-1:0] pick_gnt;
  logic [IW-1:0]   pick_idx;
  logic            pick_any;

  logic            own_req;
  logic            own_last;
  logic            accept;
  logic            release_d;
  logic            wd_expire;

  logic [DW-1:0]   x_masked [NREQ];
  logic [DW-1:0]   y_masked [NREQ];

  svi_rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .req_i (req_i),
    .ptr_i (ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  // Each slice is gated by its own grant bit; the one-hot grant turns the OR
  // below into a mux that yields 0 when nobody owns the bus.
  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_mux
      assign x_masked[gi] = gnt_q[gi] ? x_i[gi*DW +: DW] : '0;
      assign y_masked[gi] = gnt_q[gi] ? y_i[gi*DW +: DW] : '0;
    end
  endgenerate

  // OR-reduce the gated slices onto the shared bus.
  always_comb begin
    bus_x_o = '0;
    bus_y_o = '0;
    for (int i = 0; i < NREQ; i++) begin
      bus_x_o = bus_x_o | x_masked[i];
      bus_y_o = bus_y_o | y_masked[i];
    end
  end

  // Owner's request/last selected through the grant; nothing depends on bus_ready_i.
  assign own_req     = |(gnt_q & req_i);
  assign own_last    = |(gnt_q & last_i);
  assign bus_valid_o = own_req;
  assign accept      = own_req & bus_ready_i;

`ifdef SVI_ARB_WATCHDOG_EN
  localparam int WW = $clog2(TIMEOUT + 1);
  logic [WW-1:0] wd_cnt_q;

  // Expire on the stalled cycle that would bring the count to TIMEOUT, so the
  // owner holds the bus for exactly TIMEOUT beat-less cycles.
  assign wd_expire = (state_q == OWN) && own_req && !accept &&
                     (wd_cnt_q == WW'(TIMEOUT - 1));

  // Watchdog: cleared on grant, release and accepted beats; counts stalled OWN cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt_q <= '0;
    end else if (state_q != OWN || accept || release_d) begin
      wd_cnt_q <= '0;
    end else begin
      wd_cnt_q <= wd_cnt_q + 1'b1;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign wd_expire      = 1'b0;
`endif

  // Burst ends on the last accepted beat, an abandoned request, or the watchdog.
  assign release_d = (state_q == OWN) &&
                     ((accept && own_last) || !own_req || wd_expire);

  // Sequencer: arbitration, ownership, release and the registered z return.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      owner_q   <= '0;
      ptr_q     <= IW'(NREQ - 1);
      z_q       <= '0;
      z_valid_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      z_valid_q <= '0;
      timeout_q <= 1'b0;
      if (accept) begin
        z_q       <= bus_z_i;
        z_valid_q <= gnt_q;
      end
      case (state_q)
        IDLE: begin
          if (pick_any) begin
            gnt_q   <= pick_gnt;
            owner_q <= pick_idx;
            state_q <= OWN;
          end
        end
        OWN: begin
          if (release_d) begin
            gnt_q     <= '0;
            ptr_q     <= owner_q;
            state_q   <= IDLE;
            timeout_q <= wd_expire;
          end
        end
        default: begin
          gnt_q   <= '0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign gnt_o     = gnt_q;
  assign z_o       = z_q;
  assign z_valid_o = z_valid_q;
  assign busy_o    = (state_q == OWN);
  assign timeout_o = timeout_q;

endmodule

// File: tb/tb_svi_bus_arbiter.sv
// tb_svi_bus_arbiter: directed bench for svi_bus_arbiter (NREQ=4, DW=8, TIMEOUT=16).
// Watchdog scenario is included when SVI_ARB_WATCHDOG_EN is defined.
module tb_svi_bus_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 8;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [NREQ-1:0]    req_i;
  logic [NREQ-1:0]    last_i;
  logic [NREQ*DW-1:0] x_i;
  logic [NREQ*DW-1:0] y_i;
  logic [NREQ-1:0]    gnt_o;
  logic               bus_valid_o;
  logic [DW-1:0]      bus_x_o;
  logic [DW-1:0]      bus_y_o;
  logic               bus_ready_i;
  logic [DW-1:0]      bus_z_i;
  logic [DW-1:0]      z_o;
  logic [NREQ-1:0]    z_valid_o;
  logic               busy_o;
  logic               timeout_o;

  int checks = 0;
  int errors = 0;

  svi_bus_arbiter #(
    .NREQ    (NREQ),
    .DW      (DW),
    .TIMEOUT (16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_i       (req_i),
    .last_i      (last_i),
    .x_i         (x_i),
    .y_i         (y_i),
    .gnt_o       (gnt_o),
    .bus_valid_o (bus_valid_o),
    .bus_x_o     (bus_x_o),
    .bus_y_o     (bus_y_o),
    .bus_ready_i (bus_ready_i),
    .bus_z_i     (bus_z_i),
    .z_o         (z_o),
    .z_valid_o   (z_valid_o),
    .busy_o      (busy_o),
    .timeout_o   (timeout_o)
  );

  always #5 clk = ~clk;

  // Advance past the next rising edge; inputs are driven and outputs sampled here.
  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset;
    rst_n = 1'b0; req_i = '0; last_i = '0; x_i = '0; y_i = '0;
    bus_ready_i = 1'b0; bus_z_i = '0;
    #3;
    checks++; if (gnt_o !== 4'b0000) begin errors++; $display("FAIL reset_gnt got %b exp 0000", gnt_o); end
    checks++; if (z_o !== 8'h00) begin errors++; $display("FAIL reset_z got %h exp 00", z_o); end
    checks++; if (z_valid_o !== 4'b0000) begin errors++; $display("FAIL reset_zv got %b exp 0000", z_valid_o); end
    checks++; if ({busy_o, timeout_o, bus_valid_o} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b exp 000", {busy_o, timeout_o, bus_valid_o}); end
    checks++; if (bus_x_o !== 8'h00) begin errors++; $display("FAIL reset_busx got %h exp 00", bus_x_o); end
    $display("reset: gnt=%b z=%h zv=%b busy=%b", gnt_o, z_o, z_valid_o, busy_o);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_burst;
    logic [DW-1:0] zexp;
    x_i = {8'h00, 8'h55, 8'h00, 8'h00};
    y_i = {8'h00, 8'hA2, 8'h00, 8'h00};
    req_i = 4'b0100; last_i = 4'b0000; bus_ready_i = 1'b1;
    tick();
    checks++; if (gnt_o !== 4'b0100) begin errors++; $display("FAIL burst_gnt got %b exp 0100", gnt_o); end
    for (int b = 0; b < 3; b++) begin
      zexp = 8'h11 * (b + 1);
      bus_z_i = zexp;
      last_i = (b == 2) ? 4'b0100 : 4'b0000;
      #1;
      checks++; if ({bus_valid_o, bus_x_o, bus_y_o} !== {1'b1, 8'h55, 8'hA2}) begin errors++; $display("FAIL burst_bus beat %0d got v=%b x=%h y=%h exp v=1 x=55 y=a2", b, bus_valid_o, bus_x_o, bus_y_o); end
      tick();
      checks++; if ({z_valid_o, z_o} !== {4'b0100, zexp}) begin errors++; $display("FAIL burst_z beat %0d got zv=%b z=%h exp zv=0100 z=%h", b, z_valid_o, z_o, zexp); end
      $display("burst beat %0d: gnt=%b zv=%b z=%h", b, gnt_o, z_valid_o, z_o);
    end
    checks++; if (gnt_o !== 4'b0000) begin errors++; $display("FAIL burst_release got %b exp 0000", gnt_o); end
    req_i = '0; last_i = '0;
    tick();
    checks++; if ({gnt_o, z_valid_o} !== 8'h00) begin errors++; $display("FAIL burst_idle got gnt=%b zv=%b exp 0000/0000", gnt_o, z_valid_o); end
  endtask

  task automatic test_rotation;
    logic [NREQ-1:0] exp_g;
    do_reset();
    x_i = {8'h44, 8'h33, 8'h22, 8'h11};
    y_i = '0;
    req_i = 4'b1111; last_i = 4'b1111; bus_ready_i = 1'b1; bus_z_i = 8'h9C;
    for (int k = 0; k < 5; k++) begin
      exp_g = 4'b0001 << (k % 4);
      tick();
      checks++; if (gnt_o !== exp_g) begin errors++; $display("FAIL rot_gnt step %0d got %b exp %b", k, gnt_o, exp_g); end
      #1;
      checks++; if (bus_x_o !== 8'(8'h11 * ((k % 4) + 1))) begin errors++; $display("FAIL rot_busx step %0d got %h exp %h", k, bus_x_o, 8'(8'h11 * ((k % 4) + 1))); end
      tick();
      checks++; if ({gnt_o, z_valid_o} !== {4'b0000, exp_g}) begin errors++; $display("FAIL rot_gap step %0d got gnt=%b zv=%b exp 0000/%b", k, gnt_o, z_valid_o, exp_g); end
      $display("rotation step %0d: granted %b", k, exp_g);
    end
    req_i = '0; last_i = '0;
    tick();
  endtask

  task automatic test_stall;
    // ptr is 0 here, only requester 1 asks.
    x_i = {8'h00, 8'h00, 8'h3C, 8'h00};
    y_i = {8'h00, 8'h00, 8'hC3, 8'h00};
    req_i = 4'b0010; last_i = 4'b0010; bus_ready_i = 1'b0; bus_z_i = 8'hEE;
    tick();
    checks++; if (gnt_o !== 4'b0010) begin errors++; $display("FAIL stall_gnt got %b exp 0010", gnt_o); end
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++; if ({bus_valid_o, bus_x_o, bus_y_o} !== {1'b1, 8'h3C, 8'hC3}) begin errors++; $display("FAIL stall_bus cyc %0d got v=%b x=%h y=%h", c, bus_valid_o, bus_x_o, bus_y_o); end
      tick();
      checks++; if ({gnt_o, z_valid_o, timeout_o} !== {4'b0010, 4'b0000, 1'b0}) begin errors++; $display("FAIL stall_hold cyc %0d got gnt=%b zv=%b to=%b exp 0010/0000/0", c, gnt_o, z_valid_o, timeout_o); end
    end
    bus_ready_i = 1'b1; bus_z_i = 8'h5A;
    tick();
    checks++; if ({gnt_o, z_valid_o, z_o} !== {4'b0000, 4'b0010, 8'h5A}) begin errors++; $display("FAIL stall_accept got gnt=%b zv=%b z=%h exp 0000/0010/5a", gnt_o, z_valid_o, z_o); end
    $display("stall: accepted z=%h zv=%b", z_o, z_valid_o);
    req_i = '0; last_i = '0;
    tick();
  endtask

  task automatic test_abandon;
    // ptr is 1: search order 2,3,0 so requester 3 wins over 0.
    x_i = '0; y_i = '0;
    req_i = 4'b1001; last_i = 4'b0000; bus_ready_i = 1'b0; bus_z_i = 8'h77;
    tick();
    checks++; if (gnt_o !== 4'b1000) begin errors++; $display("FAIL aband_gnt got %b exp 1000", gnt_o); end
    tick();
    req_i = 4'b0001; bus_ready_i = 1'b1;
    #1;
    checks++; if (bus_valid_o !== 1'b0) begin errors++; $display("FAIL aband_valid got %b exp 0", bus_valid_o); end
    tick();
    checks++; if ({gnt_o, z_valid_o} !== 8'h00) begin errors++; $display("FAIL aband_release got gnt=%b zv=%b exp 0000/0000", gnt_o, z_valid_o); end
    tick();
    checks++; if ({gnt_o, z_valid_o} !== {4'b0001, 4'b0000}) begin errors++; $display("FAIL aband_next got gnt=%b zv=%b exp 0001/0000", gnt_o, z_valid_o); end
    $display("abandon: next owner %b", gnt_o);
    req_i = '0;
    tick();
    tick();
  endtask

  task automatic test_reset_midburst;
    req_i = 4'b0100; last_i = 4'b0000; bus_ready_i = 1'b1; bus_z_i = 8'h66;
    tick();
    tick();
    checks++; if ({gnt_o, z_valid_o} !== {4'b0100, 4'b0100}) begin errors++; $display("FAIL rstmid_pre got gnt=%b zv=%b exp 0100/0100", gnt_o, z_valid_o); end
    rst_n = 1'b0;
    #1;
    checks++; if ({gnt_o, z_valid_o, bus_valid_o} !== 9'b0) begin errors++; $display("FAIL rstmid_drop got gnt=%b zv=%b v=%b exp 0", gnt_o, z_valid_o, bus_valid_o); end
    req_i = 4'b1111; last_i = 4'b1111;
    #1;
    rst_n = 1'b1;
    tick();
    checks++; if (gnt_o !== 4'b0001) begin errors++; $display("FAIL rstmid_first got %b exp 0001", gnt_o); end
    $display("reset mid-burst: first grant after reset %b", gnt_o);
    req_i = '0; last_i = '0;
    tick();
    tick();
  endtask

`ifdef SVI_ARB_WATCHDOG_EN
  task automatic test_watchdog;
    do_reset();
    req_i = 4'b0100; last_i = 4'b0000; bus_ready_i = 1'b0;
    tick();
    checks++; if (gnt_o !== 4'b0100) begin errors++; $display("FAIL wd_gnt got %b exp 0100", gnt_o); end
    for (int c = 1; c < 16; c++) begin
      tick();
      checks++; if ({gnt_o, timeout_o} !== {4'b0100, 1'b0}) begin errors++; $display("FAIL wd_hold cyc %0d got gnt=%b to=%b exp 0100/0", c, gnt_o, timeout_o); end
    end
    req_i = 4'b0101;
    tick();
    checks++; if ({gnt_o, timeout_o} !== {4'b0000, 1'b1}) begin errors++; $display("FAIL wd_expire got gnt=%b to=%b exp 0000/1", gnt_o, timeout_o); end
    tick();
    checks++; if ({gnt_o, timeout_o} !== {4'b0001, 1'b0}) begin errors++; $display("FAIL wd_next got gnt=%b to=%b exp 0001/0", gnt_o, timeout_o); end
    $display("watchdog: released, next owner %b", gnt_o);
    req_i = '0;
    tick();
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_single_burst();
    test_rotation();
    test_stall();
    test_abandon();
    test_reset_midburst();
`ifdef SVI_ARB_WATCHDOG_EN
    test_watchdog();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
